// File: rtl/fetch_decode_stage.sv
// ----------------------------------------------------------------------------
// fetch_decode_stage
//   Front end of the 5-stage RV32I pipeline. It holds the fetch PC, drives the
//   instruction-memory address, captures the fetched word into the IF/ID
//   register, and decodes the register fields, the immediate and an
//   illegal-opcode flag for the controller and the ID/EX datapath.
//
// Optional feature macro: FD_PERF_CNT_EN
//   When defined, adds the stall_cnt / flush_cnt performance counters and
//   their output ports. When undefined, the counters and ports do not exist
//   and all other behaviour is unchanged.
//
// Parameters
//   RESET_PC   PC value loaded by reset
//   NOP_INST   bubble word (addi x0,x0,0) loaded into decode on reset/flush
//   CNT_W      performance counter width (used only with FD_PERF_CNT_EN)
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   stall        in   1      hold PC and IF/ID register (load-use hazard)
//   next_pc_sel  in   1      0 = redirect to jb_pc, 1 = sequential fetch
//   jb_pc        in   32     redirect target from execute
//   im_addr      out  32     instruction memory address (= fetch PC)
//   im_rdata     in   32     instruction word at im_addr (combinational read)
//   D_pc         out  32     PC of the instruction in decode
//   D_inst       out  32     raw instruction in decode
//   D_valid      out  1      decode holds a real instruction (0 = bubble)
//   D_out        out  24     {f7b, rs2, rs1, f3, rd, op}
//   D_imm        out  32     sign-extended immediate of D_inst
//   D_illegal    out  1      decode holds an unsupported opcode
//   stall_cnt    out  CNT_W  cycles with stall=1      (FD_PERF_CNT_EN only)
//   flush_cnt    out  CNT_W  cycles with next_pc_sel=0 (FD_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        next_pc_sel,
    input  logic [31:0] jb_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] D_pc,
    output logic [31:0] D_inst,
    output logic        D_valid,
    output logic [23:0] D_out,
    output logic [31:0] D_imm,
    output logic        D_illegal
`ifdef FD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Major opcodes (inst[6:2]) understood by this core.
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    function automatic logic is_supported(input logic [31:0] inst);
        logic ok;
        ok = 1'b0;
        case (inst[6:2])
            OP_OP, OP_OPIMM, OP_LOAD, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        // 16-bit compressed encodings are not supported.
        return ok && (inst[1:0] == 2'b11);
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] inst);
        logic [31:0] imm;
        imm = 32'b0;
        case (inst[6:2])
            OP_OPIMM, OP_LOAD, OP_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
            default:
                imm = 32'b0;
        endcase
        return imm;
    endfunction

    function automatic logic [23:0] pack_fields(input logic [31:0] inst);
        // {f7b, rs2, rs1, f3, rd, op}
        return {inst[30], inst[24:20], inst[19:15], inst[14:12],
                inst[11:7], inst[6:2]};
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: fetch PC
    // ------------------------------------------------------------------
    logic [31:0] f_pc_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_p0 <= RESET_PC;
        end else if (!next_pc_sel) begin
            // jb_pc is taken as-is; alignment is the execute stage's concern.
            f_pc_p0 <= jb_pc;
        end else if (!stall) begin
            f_pc_p0 <= f_pc_p0 + 32'd4;
        end
    end

    assign im_addr = f_pc_p0;

    // ------------------------------------------------------------------
    // Stage p1: IF/ID register
    // ------------------------------------------------------------------
    logic [31:0] d_inst_p1;
    logic [31:0] d_pc_p1;
    logic        vld_p1;

    always_ff @(posedge clk) begin
        if (rst || !next_pc_sel) begin
            // Reset and redirect both turn the word being fetched into a bubble.
            d_inst_p1 <= NOP_INST;
            d_pc_p1   <= 32'b0;
            vld_p1    <= 1'b0;
        end else if (!stall) begin
            d_inst_p1 <= im_rdata;
            d_pc_p1   <= f_pc_p0;
            vld_p1    <= 1'b1;
        end
    end

    assign D_inst    = d_inst_p1;
    assign D_pc      = d_pc_p1;
    assign D_valid   = vld_p1;
    assign D_out     = pack_fields(d_inst_p1);
    assign D_imm     = decode_imm(d_inst_p1);
    assign D_illegal = vld_p1 && !is_supported(d_inst_p1);

`ifdef FD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters: redirect and stall in one cycle count both
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!next_pc_sel) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt_w_tie;
    assign unused_cnt_w_tie = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        next_pc_sel;
    logic [31:0] jb_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] D_pc;
    logic [31:0] D_inst;
    logic        D_valid;
    logic [23:0] D_out;
    logic [31:0] D_imm;
    logic        D_illegal;
`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .next_pc_sel (next_pc_sel),
        .jb_pc       (jb_pc),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .D_pc        (D_pc),
        .D_inst      (D_inst),
        .D_valid     (D_valid),
        .D_out       (D_out),
        .D_imm       (D_imm),
        .D_illegal   (D_illegal)
`ifdef FD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 256 words, indexed by address bits [9:2].
    logic [31:0] mem [256];
    assign im_rdata = mem[im_addr[9:2]];

    logic [4:0] legal_ops [9];

    int n_cmp;
    int n_err;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_dpc;
    logic        m_v;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_legal(input logic [31:0] i);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 9; k++) if (i[6:2] == legal_ops[k]) hit = 1'b1;
        return hit && (i[1:0] == 2'b11);
    endfunction

    // Immediates built from the field-placement rules with shifts and masks.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] sgn;
        sgn = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:2])
            5'b00100, 5'b00000, 5'b11001:
                return 32'($signed(i) >>> 20);
            5'b01000:
                return (sgn << 11) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1F);
            5'b11000:
                return (sgn << 12) | (32'(i[7]) << 11) | ((i >> 20) & 32'h7E0)
                       | ((i >> 7) & 32'h1E);
            5'b01101, 5'b00101:
                return i & 32'hFFFF_F000;
            5'b11011:
                return (sgn << 20) | (i & 32'h000F_F000) | (32'(i[20]) << 11)
                       | ((i >> 20) & 32'h7FE);
            default:
                return 32'h0;
        endcase
    endfunction

    task automatic check_all();
        logic [31:0] exp_out;
        exp_out = {8'h0, i30(m_inst), m_inst[24:2]};
        chk("im_addr", im_addr, m_pc);
        chk("D_inst", D_inst, m_inst);
        chk("D_pc", D_pc, m_dpc);
        chk("D_valid", 32'(D_valid), 32'(m_v));
        chk("D_out", 32'(D_out), exp_out);
        chk("D_imm", D_imm, ref_imm(m_inst));
        chk("D_illegal", 32'(D_illegal), 32'(m_v && !ref_legal(m_inst)));
`ifdef FD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
`endif
    endtask

    function automatic logic i30(input logic [31:0] i);
        return i[30];
    endfunction

    // Drive one cycle of controls, advance the reference, then compare.
    task automatic step(input logic r, input logic s, input logic sel, input logic [31:0] jb);
        rst = r; stall = s; next_pc_sel = sel; jb_pc = jb;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h13; m_dpc = 32'h0; m_v = 1'b0;
            m_sc = 32'h0; m_fc = 32'h0;
        end else begin
            if (s) m_sc = m_sc + 1;
            if (!sel) m_fc = m_fc + 1;
            if (!sel) begin
                m_pc = jb; m_inst = 32'h13; m_dpc = 32'h0; m_v = 1'b0;
            end else if (!s) begin
                m_inst = mem[m_pc[9:2]]; m_dpc = m_pc; m_v = 1'b1;
                m_pc = m_pc + 4;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = {legal_ops[$urandom_range(0, 8)], 2'b11};
        return w;
    endfunction

    initial begin
        logic [31:0] sc0;
        logic [31:0] fc0;
        legal_ops = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                      5'b11000, 5'b01101, 5'b00101, 5'b11011};
        n_cmp = 0; n_err = 0;
        m_pc = 0; m_inst = 0; m_dpc = 0; m_v = 0; m_sc = 0; m_fc = 0;
        for (int k = 0; k < 256; k++) mem[k] = rand_word();
        mem[0]  = 32'h0050_0093;           // addi x1,x0,5
        mem[64] = 32'hFE00_0EE3;           // beq x0,x0,-4 at 0x100
        mem[65] = 32'h8000_00EF;           // jal at 0x104
        rst = 1'b1; stall = 1'b0; next_pc_sel = 1'b1; jb_pc = 32'h0;

        // Reset for two cycles, then check the reset state.
        step(1, 0, 1, 0);
        step(1, 1, 0, 32'h55);
        chk("rst_D_inst_nop", D_inst, 32'h0000_0013);
        chk("rst_D_out_nop", 32'(D_out), 32'h0000_0004);
        chk("rst_im_addr", im_addr, 32'h0);

        // Sequential fetch from 0.
        step(0, 0, 1, 0);
        chk("t1_D_imm", D_imm, 32'd5);
        chk("t1_op", 32'(D_out[4:0]), 32'h04);
        chk("t1_rd", 32'(D_out[9:5]), 32'd1);
        chk("t1_im_addr", im_addr, 32'd4);
        step(0, 0, 1, 0);

        // Stall two cycles at im_addr=8, then resume.
        step(0, 1, 1, 0);
        step(0, 1, 1, 32'h1234);
        chk("t2_hold_addr", im_addr, 32'd8);
        chk("t2_hold_dpc", D_pc, 32'd4);
        step(0, 0, 1, 0);
        chk("t2_resume", im_addr, 32'd12);

        // Redirect to 0x40.
        step(0, 0, 0, 32'h40);
        chk("t3_valid", 32'(D_valid), 32'd0);
        step(0, 0, 1, 0);
        chk("t3_dpc", D_pc, 32'h40);

        // Stall and redirect together: redirect wins, both counters advance.
`ifdef FD_PERF_CNT_EN
        sc0 = stall_cnt; fc0 = flush_cnt;
`else
        sc0 = 0; fc0 = 0;
`endif
        step(0, 1, 0, 32'h80);
        chk("t4_addr", im_addr, 32'h80);
`ifdef FD_PERF_CNT_EN
        chk("t4_stall_cnt", stall_cnt, sc0 + 1);
        chk("t4_flush_cnt", flush_cnt, fc0 + 1);
`endif

        // Branch and jump immediates.
        step(0, 0, 0, 32'h100);
        step(0, 0, 1, 0);
        chk("t5_beq_imm", D_imm, 32'hFFFF_FFFC);
        step(0, 0, 1, 0);
        chk("t5_jal_imm", D_imm, 32'hFFF0_0000);

        // PC wrap, then reset during a stall.
        step(0, 0, 0, 32'hFFFF_FFFC);
        step(0, 0, 1, 0);
        chk("t6_wrap", im_addr, 32'h0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 32'h77);
        chk("t6_rst_valid", 32'(D_valid), 32'd0);

        // Randomized traffic, including odd redirect targets and resets.
        for (int n = 0; n < 400; n++) begin
            logic r, s, sel;
            logic [31:0] jb;
            r   = ($urandom_range(0, 99) < 3);
            s   = ($urandom_range(0, 99) < 20);
            sel = ($urandom_range(0, 99) >= 12);
            jb  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FC);
            step(r, s, sel, jb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
